flags_register: RTL and testbench
=================================

Name: flags_register

Overview:
- Architectural NZCV flag store that produces the N/Z/C/V inputs consumed by the control unit's condition_checker.
- Derives flags from the execute-stage ALU result and applies them through a one-deep pending-update stage.
- Offers a forwarded view of the flags for back-to-back conditional instructions, and a shadow copy for save/restore around exceptions.

Parameters:
- WIDTH, 32, ALU result width in bits.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- alu_valid  in  1  execute stage holds a valid instruction this cycle.
- alu_result  in  WIDTH  ALU result.
- alu_carry  in  1  ALU carry-out.
- alu_overflow  in  1  ALU signed overflow.
- flag_w  in  2  flag write enables; bit1 updates N,Z; bit0 updates C,V.
- cond_ex  in  1  condition passed, from condition_checker.
- flush  in  1  discard the pending update (pipeline flush).
- save  in  1  copy flags into the shadow register.
- restore  in  1  load the architectural flags from the shadow register.
- N, Z, C, V  out  1 each  architectural flags (registered).
- fwd_n, fwd_z, fwd_c, fwd_v  out  1 each  architectural flags merged with the pending update (combinational).
- pending  out  1  an update is waiting to commit.
- flags_changed  out  1  one-cycle pulse, asserted the cycle after the architectural NZCV value changed.

Behaviour:
- Reset (async, rst_n=0): N=Z=C=V=0, shadow=0000, pending=0, flags_changed=0. Outputs hold these values until the first clk edge after rst_n rises.
- Flag derivation: n=alu_result[WIDTH-1]; z=(alu_result=={WIDTH{1'b0}}); c=alu_carry; v=alu_overflow.
- Capture at edge t: if alu_valid && cond_ex && flag_w!=2'b00 && !flush && !restore, then pend_nzcv<=derived flags, pend_we<=flag_w, pending<=1. Otherwise pending<=0.
- Commit at edge t+1: when pending=1 and no restore, the architectural register takes pend_nzcv fields selected by pend_we. Fields not selected keep their value. Latency from ALU inputs to N/Z/C/V is 2 edges.
- Back-to-back updates: a new capture and a commit of the previous one occur on the same edge. The pipeline sustains one update per cycle.
- fwd_*: for each field, the pend value if pending && the matching pend_we bit, else the architectural value. This is the source condition_checker must use.
- flush: on the edge where flush=1, the already-pending update is dropped (no commit) and nothing is captured. flush has priority over commit and capture.
- save: shadow<=fwd_* values, so an in-flight update is included.
- restore: N/Z/C/V<=shadow; pending<=0; the pending commit is discarded. restore has priority over commit, capture and flush.
- save and restore on the same edge: restore wins; save is ignored and shadow is unchanged.
- flags_changed: registered; 1 iff the architectural NZCV after the edge differs from the value before it.
- State machine (implicit, one state bit): IDLE (pending=0) and PEND (pending=1).
  - IDLE->PEND on capture.
  - PEND->PEND on capture (commit old, hold new).
  - PEND->IDLE on no capture, flush, or restore.
- Reset mid-operation: all state clears immediately and any pending update is lost.

Decomposition:
- Shared control-unit package:
  - typedef nzcv_t: packed struct {n,z,c,v}.
  - Constants FLAGW_NZ=2'b10 and FLAGW_CV=2'b01.
- One sub-module, flag_gen: combinational derivation of nzcv_t from alu_result/alu_carry/alu_overflow, parameterized by WIDTH.
- Merge, commit and shadow logic stays in the top module.

Test Plan:
- Reset/basic update: rst_n=0 then 1; alu_valid=1, cond_ex=1, flag_w=11, result=0, carry=1, ovf=0. Expected: fwd=0110 after edge 1, pending=1; N,Z,C,V=0110 after edge 2; flags_changed=1 for one cycle.
- Partial write: arch NZCV=0110; flag_w=10, result=32'h8000_0000, carry=0. Expected: NZCV=1010 (C kept at 1, V kept at 0).
- Gating: cond_ex=0 with flag_w=11, and separately alu_valid=0. Expected: pending stays 0, NZCV unchanged, flags_changed=0.
- Back-to-back with forwarding: update A (result=0, flag_w=11) then update B (result=5, flag_w=10) on consecutive cycles. Expected: fwd shows Z=1 then Z=0 one cycle apart; final NZCV=00 plus A's C,V; no update dropped.
- Flush: capture an update, then flush=1 on the next edge. Expected: NZCV unchanged, pending=0.
- Save/restore: arch NZCV=1001 plus pending update to 0100. save: shadow=0100. Later restore while another update is pending. Expected: NZCV=0100 and the pending update is discarded. save+restore on the same cycle: restore applied, shadow unchanged.

Source files
------------

// File: rtl/flags_register_pkg.sv
// flags_register_pkg: shared NZCV flag type, write-enable constants and pending-stage states
package flags_register_pkg;
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;
  typedef enum logic {IDLE, PEND} state_t;
  localparam logic [1:0] FLAGW_NZ = 2'b10;
  localparam logic [1:0] FLAGW_CV = 2'b01;
endpackage

// File: rtl/flags_register_if.sv
// flags_register_if: execute-stage flag update inputs and architectural/forwarded flag outputs
interface flags_register_if #(parameter int WIDTH = 32);
  logic             alu_valid;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             alu_overflow;
  logic [1:0]       flag_w;
  logic             cond_ex;
  logic             flush;
  logic             save;
  logic             restore;
  logic             N, Z, C, V;
  logic             fwd_n, fwd_z, fwd_c, fwd_v;
  logic             pending;
  logic             flags_changed;
  modport master (
    output alu_valid, alu_result, alu_carry, alu_overflow, flag_w, cond_ex, flush, save, restore,
    input  N, Z, C, V, fwd_n, fwd_z, fwd_c, fwd_v, pending, flags_changed
  );
  modport slave (
    input  alu_valid, alu_result, alu_carry, alu_overflow, flag_w, cond_ex, flush, save, restore,
    output N, Z, C, V, fwd_n, fwd_z, fwd_c, fwd_v, pending, flags_changed
  );
endinterface

// File: rtl/flags_register_flag_gen.sv
// flags_register_flag_gen: derives NZCV from an ALU result, carry-out and overflow
module flags_register_flag_gen
  import flags_register_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] result,
  input  logic             carry,
  input  logic             overflow,
  output nzcv_t            flags
);
  assign flags = '{n: result[WIDTH-1], z: ~|result, c: carry, v: overflow};
endmodule

// File: rtl/flags_register.sv
// flags_register: NZCV store with one-deep pending update, forwarding, flush and shadow save/restore
module flags_register
  import flags_register_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           rst_n,
  flags_register_if.slave bus
);
  nzcv_t      derived, arch, shadow, pend_nzcv, fwd, arch_nxt;
  logic [1:0] pend_we;
  state_t     state;
  logic       changed, capture, sel_nz, sel_cv;
  flags_register_flag_gen #(.WIDTH(WIDTH)) flag_gen (
    .result   (bus.alu_result),
    .carry    (bus.alu_carry),
    .overflow (bus.alu_overflow),
    .flags    (derived)
  );
  assign capture = bus.alu_valid && bus.cond_ex && |bus.flag_w && !bus.flush && !bus.restore;
  assign sel_nz  = state == PEND && |(pend_we & FLAGW_NZ);
  assign sel_cv  = state == PEND && |(pend_we & FLAGW_CV);
  always_comb begin
    fwd.n    = sel_nz ? pend_nzcv.n : arch.n;
    fwd.z    = sel_nz ? pend_nzcv.z : arch.z;
    fwd.c    = sel_cv ? pend_nzcv.c : arch.c;
    fwd.v    = sel_cv ? pend_nzcv.v : arch.v;
    arch_nxt = bus.restore ? shadow : (state == PEND && !bus.flush) ? fwd : arch;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arch      <= '0;
      shadow    <= '0;
      pend_nzcv <= '0;
      pend_we   <= '0;
      state     <= IDLE;
      changed   <= 1'b0;
    end else begin
      arch    <= arch_nxt;
      changed <= arch_nxt != arch;
      state   <= capture ? PEND : IDLE;
      if (bus.save && !bus.restore) shadow <= fwd;
      if (capture) begin
        pend_nzcv <= derived;
        pend_we   <= bus.flag_w;
      end
    end
  end
  assign {bus.N, bus.Z, bus.C, bus.V}                 = arch;
  assign {bus.fwd_n, bus.fwd_z, bus.fwd_c, bus.fwd_v} = fwd;
  assign bus.pending       = state == PEND;
  assign bus.flags_changed = changed;
endmodule

// File: tb/tb_flags_register.sv
// tb_flags_register: directed and randomized checks of flags_register against a queue-based flag model
module tb_flags_register;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  flags_register_if #(.WIDTH(32)) bus ();
  flags_register #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [3:0] val;
    logic [1:0] we;
  } upd_t;
  logic [3:0] m_arch, m_shadow;
  logic       m_changed;
  upd_t       m_q[$];
  function automatic logic [3:0] merge(logic [3:0] a, upd_t u);
    logic [3:0] r = a;
    if (u.we[1]) r[3:2] = u.val[3:2];
    if (u.we[0]) r[1:0] = u.val[1:0];
    return r;
  endfunction
  function automatic logic [3:0] m_fwd();
    return (m_q.size() != 0) ? merge(m_arch, m_q[0]) : m_arch;
  endfunction
  function automatic logic [3:0] nzcv();
    return {bus.N, bus.Z, bus.C, bus.V};
  endfunction
  function automatic logic [3:0] fwdv();
    return {bus.fwd_n, bus.fwd_z, bus.fwd_c, bus.fwd_v};
  endfunction
  task automatic m_reset();
    m_arch = 4'b0;
    m_shadow = 4'b0;
    m_changed = 1'b0;
    m_q.delete();
  endtask
  task automatic drive(input logic v, input logic [31:0] r, input logic c, input logic o,
                       input logic [1:0] fw, input logic ce, input logic fl, input logic sv,
                       input logic rs);
    bus.alu_valid = v;
    bus.alu_result = r;
    bus.alu_carry = c;
    bus.alu_overflow = o;
    bus.flag_w = fw;
    bus.cond_ex = ce;
    bus.flush = fl;
    bus.save = sv;
    bus.restore = rs;
  endtask
  task automatic idle();
    drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
  endtask
  // advance one clock and apply the architectural rules to the model
  task automatic cycle();
    logic [3:0] f = m_fwd();
    logic [3:0] old = m_arch;
    logic cap = bus.alu_valid && bus.cond_ex && bus.flag_w != 2'b00 && !bus.flush && !bus.restore;
    upd_t u;
    u.val = {bus.alu_result[31], bus.alu_result == 32'd0, bus.alu_carry, bus.alu_overflow};
    u.we = bus.flag_w;
    @(posedge clk);
    #1;
    if (bus.restore) begin
      m_arch = m_shadow;
      m_q.delete();
    end else begin
      if (!bus.flush && m_q.size() != 0) m_arch = f;
      m_q.delete();
      if (bus.save) m_shadow = f;
      if (cap) m_q.push_back(u);
    end
    m_changed = m_arch != old;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    drive(1, 0, 1, 1, 2'b11, 1, 0, 0, 0);
    m_reset();
    #12;
    total++; if (nzcv() !== 4'b0000) begin bad++; $display("FAIL reset_nzcv got=%b exp=0000", nzcv()); end
    total++; if (bus.pending !== 1'b0) begin bad++; $display("FAIL reset_pending got=%b exp=0", bus.pending); end
    total++; if (bus.flags_changed !== 1'b0) begin bad++; $display("FAIL reset_changed got=%b exp=0", bus.flags_changed); end
    total++; if (fwdv() !== 4'b0000) begin bad++; $display("FAIL reset_fwd got=%b exp=0000", fwdv()); end
    idle();
    rst_n = 1'b1;
    cycle();
  endtask
  task automatic test_basic();
    drive(1, 0, 1, 0, 2'b11, 1, 0, 0, 0);
    cycle();
    total++; if (fwdv() !== 4'b0110) begin bad++; $display("FAIL basic_fwd got=%b exp=0110", fwdv()); end
    total++; if (bus.pending !== 1'b1) begin bad++; $display("FAIL basic_pending got=%b exp=1", bus.pending); end
    total++; if (nzcv() !== 4'b0000) begin bad++; $display("FAIL basic_early got=%b exp=0000", nzcv()); end
    idle();
    cycle();
    total++; if (nzcv() !== 4'b0110) begin bad++; $display("FAIL basic_commit got=%b exp=0110", nzcv()); end
    total++; if (bus.flags_changed !== 1'b1) begin bad++; $display("FAIL basic_changed got=%b exp=1", bus.flags_changed); end
    cycle();
    total++; if (bus.flags_changed !== 1'b0) begin bad++; $display("FAIL basic_pulse got=%b exp=0", bus.flags_changed); end
  endtask
  task automatic test_partial();
    drive(1, 32'h8000_0000, 0, 1, 2'b10, 1, 0, 0, 0);
    cycle();
    idle();
    cycle();
    total++; if (nzcv() !== 4'b1010) begin bad++; $display("FAIL partial got=%b exp=1010", nzcv()); end
  endtask
  task automatic test_gating();
    drive(1, 0, 0, 1, 2'b11, 0, 0, 0, 0);
    cycle();
    total++; if (bus.pending !== 1'b0) begin bad++; $display("FAIL gate_cond_pending got=%b exp=0", bus.pending); end
    cycle();
    total++; if (nzcv() !== 4'b1010) begin bad++; $display("FAIL gate_cond_nzcv got=%b exp=1010", nzcv()); end
    drive(0, 0, 0, 1, 2'b11, 1, 0, 0, 0);
    cycle();
    total++; if (bus.pending !== 1'b0) begin bad++; $display("FAIL gate_valid_pending got=%b exp=0", bus.pending); end
    cycle();
    total++; if (nzcv() !== 4'b1010) begin bad++; $display("FAIL gate_valid_nzcv got=%b exp=1010", nzcv()); end
    total++; if (bus.flags_changed !== 1'b0) begin bad++; $display("FAIL gate_changed got=%b exp=0", bus.flags_changed); end
  endtask
  task automatic test_back_to_back();
    drive(1, 0, 1, 1, 2'b11, 1, 0, 0, 0);
    cycle();
    total++; if (fwdv() !== 4'b0111) begin bad++; $display("FAIL b2b_fwd_a got=%b exp=0111", fwdv()); end
    drive(1, 5, 0, 0, 2'b10, 1, 0, 0, 0);
    cycle();
    total++; if (fwdv() !== 4'b0011) begin bad++; $display("FAIL b2b_fwd_b got=%b exp=0011", fwdv()); end
    total++; if (nzcv() !== 4'b0111) begin bad++; $display("FAIL b2b_mid got=%b exp=0111", nzcv()); end
    idle();
    cycle();
    total++; if (nzcv() !== 4'b0011) begin bad++; $display("FAIL b2b_final got=%b exp=0011", nzcv()); end
  endtask
  task automatic test_flush();
    drive(1, 32'h8000_0000, 0, 0, 2'b11, 1, 0, 0, 0);
    cycle();
    total++; if (bus.pending !== 1'b1) begin bad++; $display("FAIL flush_pre got=%b exp=1", bus.pending); end
    drive(1, 32'h8000_0000, 0, 0, 2'b11, 1, 1, 0, 0);
    cycle();
    total++; if (nzcv() !== 4'b0011) begin bad++; $display("FAIL flush_nzcv got=%b exp=0011", nzcv()); end
    total++; if (bus.pending !== 1'b0) begin bad++; $display("FAIL flush_pending got=%b exp=0", bus.pending); end
    idle();
    cycle();
    total++; if (nzcv() !== 4'b0011) begin bad++; $display("FAIL flush_after got=%b exp=0011", nzcv()); end
  endtask
  task automatic test_save_restore();
    drive(1, 32'h8000_0000, 0, 1, 2'b11, 1, 0, 0, 0);
    cycle();
    idle();
    cycle();
    total++; if (nzcv() !== 4'b1001) begin bad++; $display("FAIL sr_setup got=%b exp=1001", nzcv()); end
    drive(1, 0, 0, 0, 2'b11, 1, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 2'b00, 0, 0, 1, 0);
    cycle();
    total++; if (nzcv() !== 4'b0100) begin bad++; $display("FAIL sr_save_commit got=%b exp=0100", nzcv()); end
    drive(1, 32'h8000_0001, 1, 1, 2'b11, 1, 0, 0, 0);
    cycle();
    idle();
    cycle();
    total++; if (nzcv() !== 4'b1011) begin bad++; $display("FAIL sr_mid got=%b exp=1011", nzcv()); end
    drive(1, 1, 1, 1, 2'b11, 1, 0, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
    cycle();
    total++; if (nzcv() !== 4'b0100) begin bad++; $display("FAIL sr_restore got=%b exp=0100", nzcv()); end
    total++; if (bus.pending !== 1'b0) begin bad++; $display("FAIL sr_restore_pending got=%b exp=0", bus.pending); end
    idle();
    cycle();
    total++; if (nzcv() !== 4'b0100) begin bad++; $display("FAIL sr_discard got=%b exp=0100", nzcv()); end
    drive(1, 32'h8000_0001, 1, 1, 2'b11, 1, 0, 0, 0);
    cycle();
    idle();
    cycle();
    drive(0, 0, 0, 0, 2'b00, 0, 0, 1, 1);
    cycle();
    total++; if (nzcv() !== 4'b0100) begin bad++; $display("FAIL sr_both got=%b exp=0100", nzcv()); end
    drive(1, 1, 1, 1, 2'b11, 1, 0, 0, 0);
    cycle();
    idle();
    cycle();
    drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 1);
    cycle();
    total++; if (nzcv() !== 4'b0100) begin bad++; $display("FAIL sr_shadow_kept got=%b exp=0100", nzcv()); end
    idle();
  endtask
  task automatic test_reset_mid();
    drive(1, 1, 1, 1, 2'b11, 1, 0, 0, 0);
    cycle();
    idle();
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    total++; if (bus.pending !== 1'b0) begin bad++; $display("FAIL rstmid_pending got=%b exp=0", bus.pending); end
    total++; if (nzcv() !== 4'b0000) begin bad++; $display("FAIL rstmid_nzcv got=%b exp=0000", nzcv()); end
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    total++; if (nzcv() !== 4'b0000) begin bad++; $display("FAIL rstmid_lost got=%b exp=0000", nzcv()); end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(3, 0) != 0,
            ($urandom_range(3, 0) == 0) ? 32'd0 : 32'($urandom),
            1'($urandom), 1'($urandom), 2'($urandom),
            $urandom_range(3, 0) != 0, $urandom_range(7, 0) == 0,
            $urandom_range(7, 0) == 0, $urandom_range(9, 0) == 0);
      cycle();
      total++; if (nzcv() !== m_arch) begin bad++; $display("FAIL rnd_nzcv i=%0d got=%b exp=%b", i, nzcv(), m_arch); end
      total++; if (fwdv() !== m_fwd()) begin bad++; $display("FAIL rnd_fwd i=%0d got=%b exp=%b", i, fwdv(), m_fwd()); end
      total++; if (bus.pending !== (m_q.size() != 0)) begin bad++; $display("FAIL rnd_pending i=%0d got=%b exp=%b", i, bus.pending, m_q.size() != 0); end
      total++; if (bus.flags_changed !== m_changed) begin bad++; $display("FAIL rnd_changed i=%0d got=%b exp=%b", i, bus.flags_changed, m_changed); end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_gating();
    test_back_to_back();
    test_flush();
    test_save_restore();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
